nvram_save_sequencer: RTL

Controller for the HPS-side port of the 8 KB NVRAM in the CD-i top level. It sequences NVRAM restore from an HPS save file after reset and gates CPU NVRAM access until that restore completes. It debounces CPU writes and streams the full NVRAM contents back to the HPS for saving. It drives the `nvram_backup_restore_adr`, `nvram_restore_data`, `nvram_restore_write` and `nvram_allow_cpu_access` nets, and consumes `nvram_backup_data` and `nvram_cpu_changed`.

---
 rtl/nvram_save_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nvram_save_sequencer.sv
// HPS-side NVRAM port controller: restore from save file, CPU access gating, debounced auto-save streaming.
// Latency: restore write lands 1 cycle after byte acceptance; save byte 2 cycles min per byte; auto-save req at T+DIRTY_DELAY+1.
// Backpressure: restore_valid/restore_ready accepts 1 byte/cycle; save_valid holds data stable until save_ready.
module nvram_save_sequencer #(
  parameter int DIRTY_DELAY = 30000000
) (
  input  logic        clk30,
  input  logic        reset,
  input  logic        restore_start,
  input  logic        restore_skip,
  input  logic [7:0]  restore_data,
  input  logic        restore_valid,
  output logic        restore_ready,
  input  logic        save_force,
  input  logic        nvram_cpu_changed,
  output logic [12:0] nvram_adr,
  output logic [7:0]  nvram_wdata,
  output logic        nvram_we,
  input  logic [7:0]  nvram_backup_data,
  output logic        nvram_allow_cpu_access,
  output logic        save_req,
  input  logic        save_ack,
  output logic [7:0]  save_data,
  output logic        save_valid,
  input  logic        save_ready,
  output logic        dirty,
  output logic        busy
);

  localparam int            CW     = $clog2(DIRTY_DELAY + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIRTY_DELAY - 1);
  localparam logic [12:0]   LAST   = 13'h1FFF;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_IDLE,
    S_RESTORE,
    S_DIRTY,
    S_SAVE_REQ,
    S_SAVE_READ,
    S_SAVE_OUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [12:0]   r_ptr, w_ptr_nxt;
  logic          r_redirty, w_redirty_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we, w_we_nxt;
  logic [12:0]   r_wadr, w_wadr_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic          w_saving;
  logic          w_redirty_now;

  // A CPU write seen during the final save byte must still leave the RAM marked dirty.
  assign w_redirty_now = r_redirty | nvram_cpu_changed;

  // State, pointer, debounce counter and the registered restore write port.
  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOCKED;
      r_ptr     <= 13'd0;
      r_redirty <= 1'b0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_wadr    <= 13'd0;
      r_wdata   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_redirty <= w_redirty_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_wadr    <= w_wadr_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  // Next-state sequencing; restore_start outranks save_force, which outranks CPU change pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_redirty_nxt = r_redirty;
    w_cnt_nxt     = r_cnt;
    w_we_nxt      = 1'b0;
    w_wadr_nxt    = r_wadr;
    w_wdata_nxt   = r_wdata;
    case (r_state)
      S_LOCKED: begin
        if (restore_start) begin
          w_state_nxt = S_RESTORE;
          w_ptr_nxt   = 13'd0;
        end else if (restore_skip) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RESTORE: begin
        if (restore_valid) begin
          w_we_nxt    = 1'b1;
          w_wadr_nxt  = r_ptr;
          w_wdata_nxt = restore_data;
          w_ptr_nxt   = r_ptr + 13'd1;
          if (r_ptr == LAST) w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (restore_start) begin
          w_state_nxt = S_RESTORE;
          w_ptr_nxt   = 13'd0;
        end else if (save_force) begin
          w_state_nxt = S_SAVE_REQ;
        end else if (nvram_cpu_changed) begin
          w_state_nxt = S_DIRTY;
          w_cnt_nxt   = RELOAD;
        end
      end
      S_DIRTY: begin
        if (restore_start) begin
          w_state_nxt   = S_RESTORE;
          w_ptr_nxt     = 13'd0;
          w_redirty_nxt = 1'b0;
        end else if (save_force) begin
          w_state_nxt = S_SAVE_REQ;
        end else if (nvram_cpu_changed) begin
          w_cnt_nxt = RELOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_SAVE_REQ;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SAVE_REQ: begin
        if (nvram_cpu_changed) w_redirty_nxt = 1'b1;
        if (save_ack) begin
          // Snapshot starts now: earlier writes are covered, a write this cycle is not guaranteed.
          w_state_nxt   = S_SAVE_READ;
          w_ptr_nxt     = 13'd0;
          w_redirty_nxt = nvram_cpu_changed;
        end
      end
      S_SAVE_READ: begin
        if (nvram_cpu_changed) w_redirty_nxt = 1'b1;
        w_state_nxt = S_SAVE_OUT;
      end
      S_SAVE_OUT: begin
        w_redirty_nxt = w_redirty_now;
        if (save_ready) begin
          w_ptr_nxt = r_ptr + 13'd1;
          if (r_ptr != LAST) begin
            w_state_nxt = S_SAVE_READ;
          end else begin
            w_redirty_nxt = 1'b0;
            if (w_redirty_now) begin
              w_state_nxt = S_DIRTY;
              w_cnt_nxt   = RELOAD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_LOCKED;
    endcase
  end

  assign w_saving = (r_state == S_SAVE_READ) || (r_state == S_SAVE_OUT);

  // Port B address follows the save pointer while streaming, else the last restore write address.
  assign nvram_adr              = w_saving ? r_ptr : r_wadr;
  assign nvram_wdata            = r_wdata;
  assign nvram_we               = r_we;
  assign restore_ready          = (r_state == S_RESTORE);
  assign nvram_allow_cpu_access = (r_state != S_LOCKED) && (r_state != S_RESTORE);
  assign save_req               = (r_state == S_SAVE_REQ);
  assign save_valid             = (r_state == S_SAVE_OUT);
  assign save_data              = save_valid ? nvram_backup_data : 8'h00;
  assign busy                   = (r_state == S_RESTORE) || (r_state == S_SAVE_REQ) || w_saving;
  assign dirty                  = (r_state == S_DIRTY) || (r_state == S_SAVE_REQ) || w_saving || r_redirty;

endmodule
